// File: rtl/rx_deframer_pkg.sv
// Shared HDLC constants, the receive FSM state type and a window bit-order helper.
package hdlc_pkg;

  localparam logic [7:0] FLAG       = 8'h7E;
  localparam logic [2:0] STUFF_ONES = 3'd5;
  localparam logic [2:0] ABORT_ONES = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OPEN = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  // Window stage 7 holds the earliest received bit, which is the byte LSB.
  function automatic logic [7:0] win_to_byte(input logic [7:0] w);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = w[7-i];
    return r;
  endfunction

endpackage

// File: rtl/rx_deframer_if.sv
// Line-side inputs and decoded outputs of the HDLC receive deframer.
interface rx_deframer_if;

  logic       Rx;
  logic       RxEN;
  logic [7:0] Rx_Data;
  logic       Rx_NewByte;
  logic       Rx_FlagDetect;
  logic       Rx_AbortDetect;
  logic       Rx_ValidFrame;
  logic       Rx_EoF;
  logic       Rx_FrameError;

  // Line driver / consumer side.
  modport master (
    output Rx, RxEN,
    input  Rx_Data, Rx_NewByte, Rx_FlagDetect, Rx_AbortDetect,
           Rx_ValidFrame, Rx_EoF, Rx_FrameError
  );

  // Deframer side.
  modport slave (
    input  Rx, RxEN,
    output Rx_Data, Rx_NewByte, Rx_FlagDetect, Rx_AbortDetect,
           Rx_ValidFrame, Rx_EoF, Rx_FrameError
  );

endinterface

// File: rtl/rx_deframer_bit_window.sv
// 8-bit raw line window with per-bit valid marks, ones run counter,
// zero-deletion marking and flag/abort decode. Decode outputs are
// combinational for the current sampled bit; the caller registers them.
module rx_bit_window
  import hdlc_pkg::*;
(
  input  logic Clk,
  input  logic Rst,
  input  logic en_i,
  input  logic bit_i,
  output logic exit_bit_o,
  output logic exit_vld_o,
  output logic flag_o,
  output logic abort_o
);

  logic [7:0] win_q, win_d;
  logic [7:0] vld_q, vld_d;
  logic [2:0] ones_q, ones_d;

  // Shift on each sampled bit; flag and abort both invalidate the whole window.
  always_comb begin
    win_d      = win_q;
    vld_d      = vld_q;
    ones_d     = ones_q;
    exit_bit_o = win_q[7];
    exit_vld_o = 1'b0;
    flag_o     = 1'b0;
    abort_o    = 1'b0;
    if (en_i) begin
      exit_vld_o = vld_q[7];
      win_d      = {win_q[6:0], bit_i};
      // A zero right after five ones is a stuffed bit, kept raw but not as data.
      vld_d      = {vld_q[6:0], ~(~bit_i && (ones_q == STUFF_ONES))};
      if (bit_i)
        ones_d = (ones_q == ABORT_ONES) ? ones_q : ones_q + 3'd1;
      else
        ones_d = 3'd0;
      // Only the 6->7 edge counts, so a held-high line aborts once.
      abort_o = bit_i && (ones_q == ABORT_ONES - 3'd1);
      flag_o  = ~abort_o && (win_to_byte(win_d) == FLAG);
      if (flag_o || abort_o) vld_d = '0;
    end
  end

  // Window state registers.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      win_q  <= '0;
      vld_q  <= '0;
      ones_q <= '0;
    end else begin
      win_q  <= win_d;
      vld_q  <= vld_d;
      ones_q <= ones_d;
    end
  end

endmodule

// File: rtl/rx_deframer.sv
// HDLC receive deframer: frame FSM and LSB-first byte assembly on top of
// the raw bit window. Every output is a register.
module rx_deframer (
  input  logic          Clk,
  input  logic          Rst,
  rx_deframer_if.slave  rx
);
  import hdlc_pkg::*;

  logic exit_bit, exit_vld, flag, abort;

  rx_bit_window u_win (
    .Clk        (Clk),
    .Rst        (Rst),
    .en_i       (rx.RxEN),
    .bit_i      (rx.Rx),
    .exit_bit_o (exit_bit),
    .exit_vld_o (exit_vld),
    .flag_o     (flag),
    .abort_o    (abort)
  );

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d;
  logic [7:0] data_q, data_d;
  logic       nb_q, nb_d;
  logic       flg_q, abt_q;
  logic       vf_q;
  logic       eof_q, eof_d;
  logic       ferr_q, ferr_d;

  // Exiting data bit is consumed first, then the flag/abort action applies.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    data_d  = data_q;
    nb_d    = 1'b0;
    eof_d   = 1'b0;
    ferr_d  = 1'b0;
    if (exit_vld && (state_q != ST_IDLE)) begin
      sh_d    = {exit_bit, sh_q[7:1]};
      cnt_d   = cnt_q + 3'd1;
      state_d = ST_DATA;
      if (cnt_q == 3'd7) begin
        data_d = sh_d;
        nb_d   = 1'b1;
      end
    end
    if (abort) begin
      state_d = ST_IDLE;
      cnt_d   = 3'd0;
    end else if (flag) begin
      // One flag both closes the current frame and opens the next.
      if (state_d == ST_DATA) begin
        eof_d  = (cnt_d == 3'd0);
        ferr_d = (cnt_d != 3'd0);
      end
      state_d = ST_OPEN;
      cnt_d   = 3'd0;
    end
  end

  // FSM, assembly and output registers.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      nb_q    <= 1'b0;
      flg_q   <= 1'b0;
      abt_q   <= 1'b0;
      vf_q    <= 1'b0;
      eof_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      nb_q    <= nb_d;
      flg_q   <= flag;
      abt_q   <= abort;
      vf_q    <= (state_d == ST_DATA);
      eof_q   <= eof_d;
      ferr_q  <= ferr_d;
    end
  end

  assign rx.Rx_Data        = data_q;
  assign rx.Rx_NewByte     = nb_q;
  assign rx.Rx_FlagDetect  = flg_q;
  assign rx.Rx_AbortDetect = abt_q;
  assign rx.Rx_ValidFrame  = vf_q;
  assign rx.Rx_EoF         = eof_q;
  assign rx.Rx_FrameError  = ferr_q;

endmodule

// File: tb/tb_rx_deframer.sv
// Directed bench for rx_deframer: each task sends a bit sequence and checks
// pulse counts and received bytes collected by a negedge monitor.
module tb_rx_deframer;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  rx_deframer_if rx();

  rx_deframer dut (.Clk(Clk), .Rst(Rst), .rx(rx));

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  int n_nb = 0, n_eof = 0, n_ferr = 0, n_flag = 0, n_abort = 0, stray = 0;
  logic [7:0] last_data = 8'h00;
  logic en_at_edge;
  bit toggle_mode = 1'b0;

  // RxEN as seen by the DUT on each edge.
  always @(posedge Clk) en_at_edge <= rx.RxEN;

  // Count pulses; a pulse after a non-sampling cycle is an error.
  always @(negedge Clk) begin
    if (rx.Rx_NewByte) begin n_nb++; last_data = rx.Rx_Data; end
    if (rx.Rx_EoF) n_eof++;
    if (rx.Rx_FrameError) n_ferr++;
    if (rx.Rx_FlagDetect) n_flag++;
    if (rx.Rx_AbortDetect) n_abort++;
    if ((en_at_edge === 1'b0) && (rx.Rx_NewByte || rx.Rx_EoF || rx.Rx_FrameError ||
        rx.Rx_FlagDetect || rx.Rx_AbortDetect)) stray++;
  end

  task automatic send_bit(input logic b);
    rx.Rx = b; rx.RxEN = 1'b1;
    @(posedge Clk); #1;
    if (toggle_mode) begin
      rx.RxEN = 1'b0; rx.Rx = ~b;
      @(posedge Clk); #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask

  task automatic send_flag();
    send_byte(8'h7E);
  endtask

  task automatic idle();
    rx.RxEN = 1'b0; rx.Rx = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    logic [13:0] outs;
    outs = {rx.Rx_Data, rx.Rx_NewByte, rx.Rx_FlagDetect, rx.Rx_AbortDetect,
            rx.Rx_ValidFrame, rx.Rx_EoF, rx.Rx_FrameError};
    total++; if (outs !== 14'h0) begin bad++; $display("FAIL reset_outs: got %h want 0", outs); end
    // Line activity while reset is held must not reach any output.
    for (int i = 0; i < 16; i++) begin rx.Rx = 1'((8'h7E >> (i % 8)) & 1); rx.RxEN = 1'b1; @(posedge Clk); #1; end
    outs = {rx.Rx_Data, rx.Rx_NewByte, rx.Rx_FlagDetect, rx.Rx_AbortDetect,
            rx.Rx_ValidFrame, rx.Rx_EoF, rx.Rx_FrameError};
    total++; if (outs !== 14'h0) begin bad++; $display("FAIL reset_hold: got %h want 0", outs); end
    rx.RxEN = 1'b0;
    Rst = 1'b0;
    @(posedge Clk); #1;
  endtask

  task automatic test_basic_a5();
    int nb0, eof0, fe0, fl0, ab0;
    nb0 = n_nb; eof0 = n_eof; fe0 = n_ferr; fl0 = n_flag; ab0 = n_abort;
    send_flag(); send_byte(8'hA5);
    for (int i = 0; i < 4; i++) send_bit(1'((8'h7E >> i) & 1));
    total++; if (rx.Rx_ValidFrame !== 1'b1) begin bad++; $display("FAIL a5_validframe: got %b want 1", rx.Rx_ValidFrame); end
    for (int i = 4; i < 8; i++) send_bit(1'((8'h7E >> i) & 1));
    idle();
    total++; if (n_nb - nb0 != 1) begin bad++; $display("FAIL a5_newbyte: got %0d want 1", n_nb - nb0); end
    total++; if (last_data !== 8'hA5) begin bad++; $display("FAIL a5_data: got %h want a5", last_data); end
    total++; if (n_eof - eof0 != 1) begin bad++; $display("FAIL a5_eof: got %0d want 1", n_eof - eof0); end
    total++; if (n_ferr - fe0 != 0) begin bad++; $display("FAIL a5_ferr: got %0d want 0", n_ferr - fe0); end
    total++; if (n_flag - fl0 != 2) begin bad++; $display("FAIL a5_flags: got %0d want 2", n_flag - fl0); end
    total++; if (n_abort - ab0 != 0) begin bad++; $display("FAIL a5_abort: got %0d want 0", n_abort - ab0); end
    total++; if (rx.Rx_ValidFrame !== 1'b0) begin bad++; $display("FAIL a5_vf_closed: got %b want 0", rx.Rx_ValidFrame); end
  endtask

  task automatic test_stuffing();
    int nb0, eof0, fe0;
    logic [8:0] stuffed;
    nb0 = n_nb; eof0 = n_eof; fe0 = n_ferr;
    stuffed = 9'b111_0_11111; // sent LSB first: 11111 0 111
    send_flag();
    for (int i = 0; i < 9; i++) send_bit(stuffed[i]);
    send_flag(); idle();
    total++; if (n_nb - nb0 != 1) begin bad++; $display("FAIL stuff_newbyte: got %0d want 1", n_nb - nb0); end
    total++; if (last_data !== 8'hFF) begin bad++; $display("FAIL stuff_data: got %h want ff", last_data); end
    total++; if (n_eof - eof0 != 1) begin bad++; $display("FAIL stuff_eof: got %0d want 1", n_eof - eof0); end
    total++; if (n_ferr - fe0 != 0) begin bad++; $display("FAIL stuff_ferr: got %0d want 0", n_ferr - fe0); end
  endtask

  task automatic test_abort();
    int nb0, eof0, fe0, ab0;
    nb0 = n_nb; eof0 = n_eof; fe0 = n_ferr; ab0 = n_abort;
    send_flag(); send_byte(8'h12);
    // One pad zero pushes the last 0x12 bit out of the window by the 7th one.
    send_bit(1'b0);
    total++; if (rx.Rx_ValidFrame !== 1'b1) begin bad++; $display("FAIL abort_vf_open: got %b want 1", rx.Rx_ValidFrame); end
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    rx.RxEN = 1'b0; @(posedge Clk); #1;
    total++; if (n_nb - nb0 != 1) begin bad++; $display("FAIL abort_newbyte: got %0d want 1", n_nb - nb0); end
    total++; if (last_data !== 8'h12) begin bad++; $display("FAIL abort_data: got %h want 12", last_data); end
    total++; if (n_abort - ab0 != 1) begin bad++; $display("FAIL abort_pulse: got %0d want 1", n_abort - ab0); end
    total++; if (rx.Rx_ValidFrame !== 1'b0) begin bad++; $display("FAIL abort_vf_fall: got %b want 0", rx.Rx_ValidFrame); end
    for (int i = 0; i < 20; i++) send_bit(1'b1);
    idle();
    total++; if (n_abort - ab0 != 1) begin bad++; $display("FAIL abort_repeat: got %0d want 1", n_abort - ab0); end
    total++; if (n_eof - eof0 != 0) begin bad++; $display("FAIL abort_eof: got %0d want 0", n_eof - eof0); end
    total++; if (n_ferr - fe0 != 0) begin bad++; $display("FAIL abort_ferr: got %0d want 0", n_ferr - fe0); end
  endtask

  task automatic test_frame_error();
    int nb0, eof0, fe0;
    logic [11:0] bits;
    nb0 = n_nb; eof0 = n_eof; fe0 = n_ferr;
    bits = 12'b1011_0100_1101; // first byte (LSB first) is 0x4D, then 4 spare bits
    send_flag();
    for (int i = 0; i < 12; i++) send_bit(bits[i]);
    send_flag(); idle();
    total++; if (n_nb - nb0 != 1) begin bad++; $display("FAIL ferr_newbyte: got %0d want 1", n_nb - nb0); end
    total++; if (last_data !== 8'h4D) begin bad++; $display("FAIL ferr_data: got %h want 4d", last_data); end
    total++; if (n_ferr - fe0 != 1) begin bad++; $display("FAIL ferr_pulse: got %0d want 1", n_ferr - fe0); end
    total++; if (n_eof - eof0 != 0) begin bad++; $display("FAIL ferr_eof: got %0d want 0", n_eof - eof0); end
  endtask

  task automatic test_rxen_toggle();
    int nb0, eof0, fe0, fl0, st0;
    nb0 = n_nb; eof0 = n_eof; fe0 = n_ferr; fl0 = n_flag; st0 = stray;
    toggle_mode = 1'b1;
    send_flag(); send_flag(); send_flag(); send_byte(8'h3C); send_flag();
    toggle_mode = 1'b0;
    idle();
    total++; if (n_flag - fl0 != 4) begin bad++; $display("FAIL tog_flags: got %0d want 4", n_flag - fl0); end
    total++; if (n_nb - nb0 != 1) begin bad++; $display("FAIL tog_newbyte: got %0d want 1", n_nb - nb0); end
    total++; if (last_data !== 8'h3C) begin bad++; $display("FAIL tog_data: got %h want 3c", last_data); end
    total++; if (n_eof - eof0 != 1) begin bad++; $display("FAIL tog_eof: got %0d want 1", n_eof - eof0); end
    total++; if (n_ferr - fe0 != 0) begin bad++; $display("FAIL tog_ferr: got %0d want 0", n_ferr - fe0); end
    total++; if (stray - st0 != 0) begin bad++; $display("FAIL tog_stray_pulse: got %0d want 0", stray - st0); end
  endtask

  task automatic test_reset_mid_frame();
    int nb0, eof0, fe0, ab0;
    logic [4:0] partial;
    partial = 5'b01101;
    send_flag();
    for (int i = 0; i < 5; i++) send_bit(partial[i]);
    rx.RxEN = 1'b0; Rst = 1'b1;
    @(posedge Clk); #1;
    Rst = 1'b0;
    total++; if (rx.Rx_ValidFrame !== 1'b0) begin bad++; $display("FAIL rstmid_vf: got %b want 0", rx.Rx_ValidFrame); end
    nb0 = n_nb; eof0 = n_eof; fe0 = n_ferr; ab0 = n_abort;
    send_flag(); send_byte(8'h81); send_flag(); idle();
    total++; if (n_nb - nb0 != 1) begin bad++; $display("FAIL rstmid_newbyte: got %0d want 1", n_nb - nb0); end
    total++; if (last_data !== 8'h81) begin bad++; $display("FAIL rstmid_data: got %h want 81", last_data); end
    total++; if (n_eof - eof0 != 1) begin bad++; $display("FAIL rstmid_eof: got %0d want 1", n_eof - eof0); end
    total++; if (n_ferr - fe0 != 0) begin bad++; $display("FAIL rstmid_ferr: got %0d want 0", n_ferr - fe0); end
    total++; if (n_abort - ab0 != 0) begin bad++; $display("FAIL rstmid_abort: got %0d want 0", n_abort - ab0); end
  endtask

  initial begin
    rx.Rx = 1'b1; rx.RxEN = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    test_reset();
    test_basic_a5();
    test_stuffing();
    test_abort();
    test_frame_error();
    test_rxen_toggle();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
